// File: rtl/cos_pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency cosine pipeline among
// NUM_REQ requesters, tagging each issued sample so its result returns home.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module cos_pipe_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = `TOTAL_WIDTH,
  parameter int PIPE_LAT = 3,
  parameter int MAX_OUT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         pipe_x,
  input  logic [DATA_W-1:0]         pipe_y,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_y,
  output logic                      idle
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_OUT);

  logic [ID_W-1:0]     ptr_reg;
  logic [PIPE_LAT-1:0] tag_valid_reg;
  logic [ID_W-1:0]     tag_id_reg [PIPE_LAT];
  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic                grant_any;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W:0]       cand;
  logic                tail_valid;
  logic [ID_W-1:0]     tail_id;

  assign tail_valid = tag_valid_reg[PIPE_LAT-1];
  assign tail_id    = tag_id_reg[PIPE_LAT-1];
  assign idle       = ~|tag_valid_reg;

  always_comb begin
    rsp_valid = '0;
    rsp_y     = '0;
    if (tail_valid) begin
      rsp_valid[tail_id] = 1'b1;
      rsp_y              = pipe_y;
    end
  end

  // A result leaving this cycle frees its slot, so a requester at its cap
  // may issue in the same cycle and its count simply holds.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [CNT_W-1:0] cnt_reg;
      logic             issue;
      logic             ret;

      assign issue        = grant_any && (grant_id == ID_W'(gi));
      assign ret          = rsp_valid[gi];
      assign eligible[gi] = req_valid[gi] && ((cnt_reg < MAX_CNT) || ret);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (issue && !ret) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (!issue && ret) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(ret && cnt_reg == '0));
      a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && !ret && cnt_reg == MAX_CNT));
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_EXT) cand = cand - NUM_REQ_EXT;
      if (!grant_found && eligible[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // Nothing may be accepted while reset is held, even if requests are up.
  assign grant_any = grant_found && rst_n;

  always_comb begin
    req_ready = '0;
    pipe_x    = '0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
      pipe_x              = req_x[grant_id*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      tag_valid_reg <= '0;
      for (int s = 0; s < PIPE_LAT; s++) tag_id_reg[s] <= '0;
    end else begin
      if (grant_any) ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= grant_id;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

endmodule
